trojan_resp_checker: RTL and testbench
======================================

# trojan_resp_checker

Hardware response checker for the 4-input trojan-detection benchmarks: consumes the (pattern, observed-output) stream that the stimulus side drives through a benchmark under test and compares each observed bit against a loaded golden truth table. It accumulates mismatch count, first failing pattern and pattern coverage, and flags pass/fail once every input pattern has been seen. It sits at the receiving end of the exhaustive-stimulus path, replacing offline file comparison.

## Interface
- N_W, 4, stimulus pattern width; table depth is 2**N_W
- CNT_W, 8, mismatch counter width (saturating)

- CK  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- gold_we  in  1  golden-table write strobe
- gold_addr  in  N_W  golden-table entry index (= input pattern)
- gold_data  in  1  expected output for gold_addr
- start  in  1  begin/restart a check run
- obs_valid  in  1  observation present
- obs_ready  out  1  checker accepts observation
- obs_pattern  in  N_W  applied input pattern N
- obs_bit  in  1  observed output_single
- busy  out  1  run in progress
- done  out  1  all 2**N_W patterns observed
- pass  out  1  done and zero mismatches
- mismatch_cnt  out  CNT_W  mismatches this run
- first_fail_valid  out  1  first_fail_pattern is meaningful
- first_fail_pattern  out  N_W  pattern of first mismatch
- coverage  out  2**N_W  bit k set once pattern k observed

## Operation
- States: IDLE, RUN, DONE (enum in package).
- IDLE: golden writes accepted; obs_ready=0; start -> RUN, clearing mismatch_cnt, first_fail_*, coverage.
- RUN: obs_ready=1; transfer when obs_valid&&obs_ready. Compare obs_bit with table[obs_pattern]; mismatch increments mismatch_cnt (saturate at 2**CNT_W-1); first mismatch of run latches first_fail_pattern and sets first_fail_valid; coverage[obs_pattern] set. Repeated pattern: compared and counted again, coverage unchanged.
- RUN -> DONE when coverage becomes all-ones (including the transfer completing it).
- DONE: done=1, pass=(mismatch_cnt==0), obs_ready=0, stats held; start -> RUN with stats cleared.
- gold_we honoured in IDLE and DONE only; ignored in RUN (table stable during a run). Golden table retained across runs.
- start in RUN: ignored.
- busy=1 exactly in RUN.

## Timing
- Reset (reset==0 at edge): state IDLE; obs_ready, busy, done, pass, first_fail_valid = 0; mismatch_cnt, first_fail_pattern, coverage = 0; golden table cleared to 0. Reset mid-run aborts without any further update.
- Golden write: table entry updated at the edge where gold_we=1; readable by a transfer one cycle later.
- Start: sampled at edge t; busy/obs_ready high from t+1.
- Observation latency 1: transfer at edge t -> mismatch_cnt, first_fail_*, coverage updated after edge t+1 (one registered compare stage); done/pass valid after edge t+2 of the completing transfer. obs_ready drops with done (no transfer accepted once coverage is full; in-flight compare still retired).
- Back-to-back transfers every cycle supported; no bubbles.

## Structure
- Package trojan_chk_pkg: state enum chk_state_t, default N_W/CNT_W localparams, pattern_t typedef.
- Sub-module resp_golden_table: 2**N_W x 1 register file, sync write, async read, sync active-low clear.
- Top holds FSM, compare pipeline register, counters, coverage vector.

## Test plan
- Load table = parity of pattern; start; stream 0000..1111 with matching bits -> done after 16 transfers +2 cycles, pass=1, mismatch_cnt=0, coverage=16'hFFFF.
- Same, obs_bit inverted on patterns 0101 and 1100 -> mismatch_cnt=2, first_fail_pattern=0101, pass=0.
- Stream 0000 three times then rest, 0000 wrong each time -> mismatch_cnt=3, coverage full only after 1111, done then.
- CNT_W=2, all 16 wrong -> mismatch_cnt saturates at 3.
- gold_we during RUN flipping entry 0011 -> ignored; 0011 compared against original value.
- reset low after 8 transfers -> all outputs 0, table 0; new start with fresh load completes normally.

Source files
------------

// File: rtl/trojan_chk_pkg.sv
// Shared types and default widths for the trojan-benchmark response checker.
package trojan_chk_pkg;

    localparam int N_W_DEF   = 4;
    localparam int CNT_W_DEF = 8;

    typedef logic [N_W_DEF-1:0] pattern_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_t;

endpackage

// File: rtl/resp_golden_table.sv
// Golden truth table: one expected output bit per input pattern.
// Synchronous write, asynchronous read, synchronous active-low clear.
module resp_golden_table
    import trojan_chk_pkg::*;
#(
    parameter int N_W = N_W_DEF
) (
    input  logic           CK_i,
    input  logic           reset_i,
    input  logic           we_i,
    input  logic [N_W-1:0] waddr_i,
    input  logic           wdata_i,
    input  logic [N_W-1:0] raddr_i,
    output logic           rdata_o
);

    logic [2**N_W-1:0] mem_q;

    always_ff @(posedge CK_i) begin
        if (!reset_i) begin
            mem_q <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/trojan_resp_checker.sv
// Compares an observed (pattern, bit) stream against the golden table and
// accumulates mismatch count, first failing pattern and pattern coverage.
module trojan_resp_checker
    import trojan_chk_pkg::*;
#(
    parameter int N_W   = N_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic               CK_i,
    input  logic               reset_i,
    input  logic               gold_we_i,
    input  logic [N_W-1:0]     gold_addr_i,
    input  logic               gold_data_i,
    input  logic               start_i,
    input  logic               obs_valid_i,
    output logic               obs_ready_o,
    input  logic [N_W-1:0]     obs_pattern_i,
    input  logic               obs_bit_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic [CNT_W-1:0]   mismatch_cnt_o,
    output logic               first_fail_valid_o,
    output logic [N_W-1:0]     first_fail_pattern_o,
    output logic [2**N_W-1:0]  coverage_o
);

    localparam int               DEPTH   = 2**N_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    chk_state_t state_q, state_d;

    logic             statsClr;
    logic             covFull;
    logic             xfer;
    logic             goldWe;
    logic             goldBit;

    logic             cmpValid_q;
    logic [N_W-1:0]   cmpPattern_q;
    logic             cmpMismatch_q;

    logic [CNT_W-1:0] mismatchCnt_q;
    logic             firstFailValid_q;
    logic [N_W-1:0]   firstFailPattern_q;
    logic [DEPTH-1:0] coverage_q;

    // No new transfer once every pattern is covered; the last compare still retires.
    assign covFull     = &coverage_q;
    assign obs_ready_o = (state_q == RUN) && !covFull;
    assign xfer        = obs_valid_i && obs_ready_o;
    assign goldWe      = gold_we_i && (state_q != RUN);

    resp_golden_table #(
        .N_W(N_W)
    ) u_table (
        .CK_i    (CK_i),
        .reset_i (reset_i),
        .we_i    (goldWe),
        .waddr_i (gold_addr_i),
        .wdata_i (gold_data_i),
        .raddr_i (obs_pattern_i),
        .rdata_o (goldBit)
    );

    always_ff @(posedge CK_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        statsClr = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d  = RUN;
                    statsClr = 1'b1;
                end
            end
            RUN: begin
                if (covFull) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CK_i) begin
        if (!reset_i) begin
            cmpValid_q    <= 1'b0;
            cmpPattern_q  <= '0;
            cmpMismatch_q <= 1'b0;
        end else begin
            cmpValid_q <= xfer;
            if (xfer) begin
                cmpPattern_q  <= obs_pattern_i;
                cmpMismatch_q <= obs_bit_i ^ goldBit;
            end
        end
    end

    always_ff @(posedge CK_i) begin
        if (!reset_i || statsClr) begin
            mismatchCnt_q      <= '0;
            firstFailValid_q   <= 1'b0;
            firstFailPattern_q <= '0;
            coverage_q         <= '0;
        end else if (cmpValid_q) begin
            coverage_q[cmpPattern_q] <= 1'b1;
            if (cmpMismatch_q) begin
                if (mismatchCnt_q != CNT_MAX) begin
                    mismatchCnt_q <= mismatchCnt_q + CNT_W'(1);
                end
                if (!firstFailValid_q) begin
                    firstFailValid_q   <= 1'b1;
                    firstFailPattern_q <= cmpPattern_q;
                end
            end
        end
    end

    assign busy_o               = (state_q == RUN);
    assign done_o               = (state_q == DONE);
    assign pass_o               = (state_q == DONE) && (mismatchCnt_q == '0);
    assign mismatch_cnt_o       = mismatchCnt_q;
    assign first_fail_valid_o   = firstFailValid_q;
    assign first_fail_pattern_o = firstFailPattern_q;
    assign coverage_o           = coverage_q;

endmodule

// File: tb/tb_trojan_resp_checker.sv
// Self-checking bench for trojan_resp_checker: table-driven runs, hand-written
// corner sequences and randomized runs checked against a behavioural model.
module tb_trojan_resp_checker;
    import trojan_chk_pkg::*;

    localparam logic [15:0] PARITY = 16'h6996;

    typedef struct {
        string       name;
        logic        doLoad;
        logic [15:0] gold;
        logic [15:0] flip;
        int          rep;
        logic [7:0]  expCnt;
        logic [1:0]  expCntSmall;
        logic        expFfv;
        logic [3:0]  expFf;
        logic        expPass;
    } vec_t;

    logic        CK = 1'b0;
    logic        resetN;
    logic        goldWe;
    logic [3:0]  goldAddr;
    logic        goldData;
    logic        start;
    logic        obsValid;
    logic [3:0]  obsPattern;
    logic        obsBit;

    logic        obsReady, busy, done, pass, ffv;
    logic [7:0]  cnt;
    logic [3:0]  ff;
    logic [15:0] coverage;

    logic        sReady, sBusy, sDone, sPass, sFfv;
    logic [1:0]  sCnt;
    logic [3:0]  sFf;
    logic [15:0] sCov;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 CK = ~CK;

    trojan_resp_checker #(.N_W(4), .CNT_W(8)) dut (
        .CK_i(CK), .reset_i(resetN),
        .gold_we_i(goldWe), .gold_addr_i(goldAddr), .gold_data_i(goldData),
        .start_i(start), .obs_valid_i(obsValid), .obs_ready_o(obsReady),
        .obs_pattern_i(obsPattern), .obs_bit_i(obsBit),
        .busy_o(busy), .done_o(done), .pass_o(pass), .mismatch_cnt_o(cnt),
        .first_fail_valid_o(ffv), .first_fail_pattern_o(ff), .coverage_o(coverage)
    );

    trojan_resp_checker #(.N_W(4), .CNT_W(2)) dutSmall (
        .CK_i(CK), .reset_i(resetN),
        .gold_we_i(goldWe), .gold_addr_i(goldAddr), .gold_data_i(goldData),
        .start_i(start), .obs_valid_i(obsValid), .obs_ready_o(sReady),
        .obs_pattern_i(obsPattern), .obs_bit_i(obsBit),
        .busy_o(sBusy), .done_o(sDone), .pass_o(sPass), .mismatch_cnt_o(sCnt),
        .first_fail_valid_o(sFfv), .first_fail_pattern_o(sFf), .coverage_o(sCov)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic loadTable(input logic [15:0] tbl);
        for (int k = 0; k < 16; k++) begin
            @(negedge CK);
            goldWe   = 1'b1;
            goldAddr = 4'(k);
            goldData = tbl[k];
        end
    endtask

    task automatic startRun();
        @(negedge CK);
        goldWe = 1'b0;
        start  = 1'b1;
        @(negedge CK);
        start  = 1'b0;
    endtask

    // Loads (optionally), starts, streams the run back-to-back and checks the end state.
    task automatic applyStimulus(input vec_t v);
        int seq[$];
        if (v.doLoad) loadTable(v.gold);
        startRun();
        checkOutput($sformatf("%s busy after start", v.name), 32'(busy), 32'd1);
        checkOutput($sformatf("%s cnt cleared", v.name), 32'(cnt), 32'd0);
        checkOutput($sformatf("%s ffv cleared", v.name), 32'(ffv), 32'd0);
        checkOutput($sformatf("%s cov cleared", v.name), 32'(coverage), 32'd0);
        seq = {};
        for (int r = 0; r < v.rep; r++) seq.push_back(0);
        for (int p = 1; p < 16; p++) seq.push_back(p);
        foreach (seq[i]) begin
            checkOutput($sformatf("%s ready #%0d", v.name, i), 32'(obsReady), 32'd1);
            obsValid   = 1'b1;
            obsPattern = 4'(seq[i]);
            obsBit     = v.gold[seq[i]] ^ v.flip[seq[i]];
            @(negedge CK);
        end
        obsValid = 1'b0;
        checkOutput($sformatf("%s cov before last", v.name), 32'(coverage), 32'h7FFF);
        checkOutput($sformatf("%s done early", v.name), 32'(done), 32'd0);
        @(negedge CK);
        checkOutput($sformatf("%s cov full", v.name), 32'(coverage), 32'hFFFF);
        checkOutput($sformatf("%s done t+1", v.name), 32'(done), 32'd0);
        checkOutput($sformatf("%s ready t+1", v.name), 32'(obsReady), 32'd0);
        @(negedge CK);
        checkOutput($sformatf("%s done t+2", v.name), 32'(done), 32'd1);
        checkOutput($sformatf("%s busy end", v.name), 32'(busy), 32'd0);
        checkOutput($sformatf("%s pass", v.name), 32'(pass), 32'(v.expPass));
        checkOutput($sformatf("%s cnt", v.name), 32'(cnt), 32'(v.expCnt));
        checkOutput($sformatf("%s cnt small", v.name), 32'(sCnt), 32'(v.expCntSmall));
        checkOutput($sformatf("%s ffv", v.name), 32'(ffv), 32'(v.expFfv));
        checkOutput($sformatf("%s ff", v.name), 32'(ff), 32'(v.expFf));
    endtask

    // Random valid/pattern/bit stream; the model decides acceptance from the
    // coverage the checker can see and scores the run from the accepted list.
    task automatic randomRun(input int runIdx);
        logic [15:0] tbl, visCov, inFlight, justSent, expCov;
        logic        prevFull, expDone, expReady, sawDone;
        int          accPat[$];
        bit          accBit[$];
        int          expCnt, firstFail;
        tbl = 16'($urandom);
        loadTable(tbl);
        startRun();
        visCov = '0; inFlight = '0; justSent = '0; prevFull = 1'b0; sawDone = 1'b0;
        accPat = {}; accBit = {};
        for (int cyc = 0; cyc < 2000; cyc++) begin
            visCov   = visCov | inFlight;
            inFlight = justSent;
            justSent = '0;
            expDone  = prevFull;
            prevFull = (visCov == 16'hFFFF);
            checkOutput($sformatf("rand%0d done c%0d", runIdx, cyc), 32'(done), 32'(expDone));
            if (expDone) begin
                sawDone = 1'b1;
                break;
            end
            expReady = (visCov != 16'hFFFF);
            checkOutput($sformatf("rand%0d ready c%0d", runIdx, cyc), 32'(obsReady), 32'(expReady));
            checkOutput($sformatf("rand%0d busy c%0d", runIdx, cyc), 32'(busy), 32'd1);
            obsValid   = ($urandom_range(0, 3) != 0);
            obsPattern = 4'($urandom_range(0, 15));
            obsBit     = tbl[obsPattern] ^ ($urandom_range(0, 4) == 0);
            goldWe     = ($urandom_range(0, 7) == 0);
            goldAddr   = 4'($urandom_range(0, 15));
            goldData   = 1'($urandom_range(0, 1));
            if (obsValid && expReady) begin
                accPat.push_back(int'(obsPattern));
                accBit.push_back(obsBit);
                justSent = 16'(1) << obsPattern;
            end
            @(negedge CK);
        end
        obsValid = 1'b0;
        goldWe   = 1'b0;
        if (!sawDone) checkOutput($sformatf("rand%0d timeout", runIdx), 32'd0, 32'd1);
        expCnt = 0; firstFail = -1; expCov = '0;
        foreach (accPat[i]) begin
            if (accBit[i] != tbl[accPat[i]]) begin
                expCnt++;
                if (firstFail < 0) firstFail = accPat[i];
            end
            expCov[accPat[i]] = 1'b1;
        end
        checkOutput($sformatf("rand%0d cov", runIdx), 32'(coverage), 32'(expCov));
        checkOutput($sformatf("rand%0d cnt", runIdx), 32'(cnt), 32'((expCnt > 255) ? 255 : expCnt));
        checkOutput($sformatf("rand%0d cnt small", runIdx), 32'(sCnt), 32'((expCnt > 3) ? 3 : expCnt));
        checkOutput($sformatf("rand%0d pass", runIdx), 32'(pass), 32'(expCnt == 0));
        checkOutput($sformatf("rand%0d ffv", runIdx), 32'(ffv), 32'(firstFail >= 0));
        if (firstFail >= 0) checkOutput($sformatf("rand%0d ff", runIdx), 32'(ff), 32'(firstFail));
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = '{"parity ok",   1'b1, PARITY,   16'h0000, 1, 8'd0,  2'd0, 1'b0, 4'd0,  1'b1};
        vecs[1] = '{"two flips",   1'b1, PARITY,   16'h1020, 1, 8'd2,  2'd2, 1'b1, 4'd5,  1'b0};
        vecs[2] = '{"repeat zero", 1'b1, PARITY,   16'h0001, 3, 8'd3,  2'd3, 1'b1, 4'd0,  1'b0};
        vecs[3] = '{"all wrong",   1'b1, PARITY,   16'hFFFF, 1, 8'd16, 2'd3, 1'b1, 4'd0,  1'b0};
        vecs[4] = '{"a5 last",     1'b1, 16'hA5A5, 16'h8000, 1, 8'd1,  2'd1, 1'b1, 4'd15, 1'b0};
        vecs[5] = '{"zero table",  1'b1, 16'h0000, 16'h0000, 2, 8'd0,  2'd0, 1'b0, 4'd0,  1'b1};

        resetN = 1'b0; goldWe = 1'b0; goldAddr = '0; goldData = 1'b0;
        start = 1'b0; obsValid = 1'b0; obsPattern = '0; obsBit = 1'b0;
        repeat (2) @(negedge CK);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset ready", 32'(obsReady), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset pass", 32'(pass), 32'd0);
        checkOutput("reset cnt", 32'(cnt), 32'd0);
        checkOutput("reset ffv", 32'(ffv), 32'd0);
        checkOutput("reset cov", 32'(coverage), 32'd0);
        resetN = 1'b1;

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        // Table write and start pulse during RUN must both be ignored.
        loadTable(PARITY);
        startRun();
        for (int p = 0; p < 16; p++) begin
            obsValid   = 1'b1;
            obsPattern = 4'(p);
            obsBit     = PARITY[p] ^ (p == 1);
            goldWe     = (p == 2);
            goldAddr   = 4'd3;
            goldData   = 1'b1;
            start      = (p == 4);
            @(negedge CK);
        end
        obsValid = 1'b0; goldWe = 1'b0; start = 1'b0;
        repeat (2) @(negedge CK);
        checkOutput("run-write done", 32'(done), 32'd1);
        checkOutput("run-write cnt", 32'(cnt), 32'd1);
        checkOutput("run-write ff", 32'(ff), 32'd1);
        checkOutput("run-write pass", 32'(pass), 32'd0);

        // A write while DONE is honoured and kept for the next run.
        @(negedge CK);
        goldWe = 1'b1; goldAddr = 4'd3; goldData = 1'b1;
        applyStimulus('{"done write", 1'b0, PARITY ^ 16'h0008, 16'h0000, 1, 8'd0, 2'd0, 1'b0, 4'd0, 1'b1});

        // Reset in the middle of a run with a compare in flight.
        loadTable(PARITY);
        startRun();
        for (int p = 0; p < 8; p++) begin
            obsValid   = 1'b1;
            obsPattern = 4'(p);
            obsBit     = PARITY[p] ^ (p == 2);
            @(negedge CK);
        end
        obsPattern = 4'd8;
        resetN     = 1'b0;
        @(negedge CK);
        checkOutput("midreset busy", 32'(busy), 32'd0);
        checkOutput("midreset ready", 32'(obsReady), 32'd0);
        checkOutput("midreset done", 32'(done), 32'd0);
        checkOutput("midreset cnt", 32'(cnt), 32'd0);
        checkOutput("midreset cnt small", 32'(sCnt), 32'd0);
        checkOutput("midreset ffv", 32'(ffv), 32'd0);
        checkOutput("midreset ff", 32'(ff), 32'd0);
        checkOutput("midreset cov", 32'(coverage), 32'd0);
        resetN   = 1'b1;
        obsValid = 1'b0;
        applyStimulus('{"cleared table", 1'b0, 16'h0000, 16'h0000, 1, 8'd0, 2'd0, 1'b0, 4'd0, 1'b1});
        applyStimulus('{"reload",        1'b1, PARITY,   16'h0000, 1, 8'd0, 2'd0, 1'b0, 4'd0, 1'b1});

        for (int r = 0; r < 8; r++) randomRun(r);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
